ps2_key_decoder: RTL and testbench

- Converts the raw PS/2 keyboard wire pair into the 11-bit `ps2_key` event word consumed by core tops.
- Event word layout: bit10 = toggle on every event, bit9 = pressed, bit8 = extended, bits 7:0 = scancode.
- Sits between the board PS/2 pins and the key-decode `always` block in `emu`, running on `clk_sys` (~18 MHz).
- Handles frame reception, parity/stop checking, E0/F0/E1 prefix tracking and stall timeout.

---
 rtl/ps2_key_decoder.sv | 177 +++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: conditions the raw clock/data pins, frames bytes and
// folds E0/F0/E1 prefixes into the 11-bit {toggle, pressed, extended, code} key word.
module ps2_key_decoder #(
    parameter int FILT    = 8,
    parameter int TIMEOUT = 36000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] ps2_key,
    output logic        frame_err
);

    localparam int FW = $clog2(FILT + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t        state, state_nxt;
    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic          clk_filt;
    logic [FW-1:0] filt_cnt;
    logic          fall_evt;
    logic [TW-1:0] to_cnt;
    logic          timeout_hit;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_reg;
    logic          par_bit;
    logic          byte_done, err_set;
    logic          vld_p1;
    logic [7:0]    byte_p1;
    logic          ext_flag, rel_flag;
    logic [2:0]    skip_cnt;

    // Controller and keep-alive bytes that never produce a key event
    function automatic logic is_drop(input logic [7:0] b);
        case (b)
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: return 1'b1;
            default:                                                 return 1'b0;
        endcase
    endfunction

    // Stage 0: synchronisers and clock deglitch filter
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
            clk_filt <= 1'b1;
            filt_cnt <= '0;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
            if (clk_s2 == clk_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILT - 1)) begin
                clk_filt <= clk_s2;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    // The sample strobe coincides with the cycle the filtered level drops
    assign fall_evt    = clk_filt && !clk_s2 && (filt_cnt == FW'(FILT - 1));
    assign timeout_hit = (state != IDLE) && !fall_evt && (to_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (timeout_hit) begin
            state_nxt = IDLE;
        end else if (fall_evt) begin
            case (state)
                IDLE:    if (!dat_s2) state_nxt = DATA;
                DATA:    if (bit_cnt == 3'd7) state_nxt = PARITY;
                PARITY:  state_nxt = STOP;
                STOP:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        byte_done = 1'b0;
        err_set   = timeout_hit;
        if (state == STOP && fall_evt) begin
            if (dat_s2 && (^{shift_reg, par_bit})) byte_done = 1'b1;
            else                                   err_set   = 1'b1;
        end
    end

    // Stage 0: frame shift register and stall timer
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
            par_bit   <= 1'b0;
            to_cnt    <= '0;
        end else begin
            if (fall_evt || state == IDLE) to_cnt <= '0;
            else                           to_cnt <= to_cnt + 1'b1;
            if (timeout_hit) begin
                bit_cnt   <= '0;
                shift_reg <= '0;
            end else if (fall_evt) begin
                case (state)
                    IDLE:   bit_cnt <= '0;
                    DATA: begin
                        shift_reg <= {dat_s2, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 1'b1;
                    end
                    PARITY: par_bit <= dat_s2;
                    default: ;
                endcase
            end
        end
    end

    // Stage 1: completed byte and error strobe
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1    <= 1'b0;
            byte_p1   <= '0;
            frame_err <= 1'b0;
        end else begin
            vld_p1    <= byte_done;
            frame_err <= err_set;
            if (byte_done) byte_p1 <= shift_reg;
        end
    end

    // Stage 2: prefix tracking and key word update
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ps2_key  <= '0;
            ext_flag <= 1'b0;
            rel_flag <= 1'b0;
            skip_cnt <= '0;
        end else begin
            if (vld_p1) begin
                if (skip_cnt != 3'd0) begin
                    skip_cnt <= skip_cnt - 1'b1;
                end else if (byte_p1 == 8'hE1) begin
                    skip_cnt <= 3'd7;
                    ext_flag <= 1'b0;
                    rel_flag <= 1'b0;
                end else if (byte_p1 == 8'hE0) begin
                    ext_flag <= 1'b1;
                end else if (byte_p1 == 8'hF0) begin
                    rel_flag <= 1'b1;
                end else if (is_drop(byte_p1)) begin
                    ext_flag <= 1'b0;
                    rel_flag <= 1'b0;
                end else begin
                    ps2_key  <= {~ps2_key[10], ~rel_flag, ext_flag, byte_p1};
                    ext_flag <= 1'b0;
                    rel_flag <= 1'b0;
                end
            end
            if (err_set) begin
                ext_flag <= 1'b0;
                rel_flag <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: stimulus pushes expected key words and
// error pulses; a monitor pops them as the DUT changes ps2_key or pulses frame_err.
module tb_ps2_key_decoder;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [10:0] ps2_key;
    logic        frame_err;

    typedef struct {
        logic        is_err;
        logic [10:0] key;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    int          checks = 0;
    int          errors = 0;
    logic        tog = 1'b0;
    logic [10:0] prev_key = '0;

    ps2_key_decoder #(.FILT(8), .TIMEOUT(36000)) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .ps2_key   (ps2_key),
        .frame_err (frame_err)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    // bits 9:0 are hand-computed; the toggle bit follows the event count
    task automatic push_key(input logic [9:0] v);
        exp_t x;
        tog = ~tog;
        x.is_err = 1'b0;
        x.key = {tog, v};
        q.push_back(x);
    endtask

    task automatic push_err();
        exp_t x;
        x.is_err = 1'b1;
        x.key = '0;
        q.push_back(x);
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        cyc(40);
        ps2_clk = 1'b0;
        cyc(40);
        ps2_clk = 1'b1;
    endtask

    task automatic send_tail(input logic [7:0] d, input logic bad_par, input logic stop);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit((~^d) ^ bad_par);
        send_bit(stop);
        ps2_data = 1'b1;
        cyc(40);
    endtask

    task automatic send_byte(input logic [7:0] d);
        send_bit(1'b0);
        send_tail(d, 1'b0, 1'b1);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 3000) begin
            cyc(1);
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected events never seen, want 0 pending", q.size());
            q.delete();
        end
    endtask

    always @(negedge clk_sys) begin
        if (!reset_n) begin
            prev_key = '0;
        end else begin
            if (frame_err) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL frame_err: unexpected pulse, got 1 want 0");
                end else begin
                    e = q.pop_front();
                    if (!e.is_err) begin
                        errors++;
                        $display("FAIL frame_err: got error pulse, want key %h", e.key);
                    end
                end
            end
            if (ps2_key != prev_key) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL key_event: unexpected ps2_key %h, want no change from %h", ps2_key, prev_key);
                end else begin
                    e = q.pop_front();
                    if (e.is_err || ps2_key != e.key) begin
                        errors++;
                        $display("FAIL key_event: got %h, want %s %h", ps2_key,
                                 e.is_err ? "err" : "key", e.key);
                    end
                end
            end
            prev_key = ps2_key;
        end
    end

    initial begin
        cyc(5);
        checks++;
        if (ps2_key !== 11'h000 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got key %h err %b, want 000 0", ps2_key, frame_err);
        end
        reset_n = 1'b1;
        cyc(20);

        // plain make code
        push_key(10'h21C);
        send_byte(8'h1C);
        drain();

        // extended press then release
        push_key(10'h375);
        send_byte(8'hE0);
        send_byte(8'h75);
        drain();
        push_key(10'h175);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        drain();

        // parity error clears a pending E0
        send_byte(8'hE0);
        push_err();
        send_bit(1'b0);
        send_tail(8'h1C, 1'b1, 1'b1);
        push_key(10'h21C);
        send_byte(8'h1C);
        drain();

        // bad stop bit
        push_err();
        send_bit(1'b0);
        send_tail(8'h1C, 1'b0, 1'b0);
        drain();

        // stall after four data bits
        push_err();
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        ps2_data = 1'b1;
        cyc(36100);
        drain();
        push_key(10'h229);
        send_byte(8'h29);
        drain();

        // short glitch ignored, long low pulse acts as start bit
        ps2_data = 1'b0;
        cyc(5);
        ps2_clk = 1'b0;
        cyc(5);
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        cyc(60);
        push_key(10'h21C);
        send_byte(8'h1C);
        drain();
        ps2_data = 1'b0;
        cyc(5);
        ps2_clk = 1'b0;
        cyc(12);
        ps2_clk = 1'b1;
        cyc(30);
        push_key(10'h229);
        send_tail(8'h29, 1'b0, 1'b1);
        drain();

        // pause sequence and controller bytes produce nothing
        send_byte(8'hE1);
        send_byte(8'h14);
        send_byte(8'h77);
        send_byte(8'hE1);
        send_byte(8'hF0);
        send_byte(8'h14);
        send_byte(8'hF0);
        send_byte(8'h77);
        send_byte(8'hAA);
        send_byte(8'hE0);
        send_byte(8'hFA);
        push_key(10'h21C);
        send_byte(8'h1C);
        drain();

        // reset in the middle of a frame
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        reset_n = 1'b0;
        tog = 1'b0;
        cyc(3);
        checks++;
        if (ps2_key !== 11'h000 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got key %h err %b, want 000 0", ps2_key, frame_err);
        end
        ps2_data = 1'b1;
        cyc(2);
        reset_n = 1'b1;
        cyc(100);
        push_key(10'h216);
        send_byte(8'h16);
        drain();
        cyc(200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
